bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one external memory bus between instruction fetch (IF port) and load/store (MEM port) of the 5-stage pipeline.
- Grants one requester at a time and holds the grant until the slave acknowledges or a timeout fires.
- Returns read data and a one-cycle ack to the granted requester.
- Drives per-port stall requests back to the pipeline while a port is waiting.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width; byte-select width is DATA_W/8
TIMEOUT, 255, max cycles bus_stb_o may stay high without bus_ack_i before abort (1..255, 8-bit counter)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_req_i  in  1  fetch request, held until if_ack_o
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
if_rdata_o  out  DATA_W  fetched word, valid in if_ack_o cycle, held after
if_ack_o  out  1  one-cycle completion pulse
stallreq_if_o  out  1  if_req_i & ~if_ack_o (combinational)
mem_req_i  in  1  data request, held until mem_ack_o
mem_we_i  in  1  1=write
mem_sel_i  in  DATA_W/8  byte enables
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  store data
mem_rdata_o  out  DATA_W  load data, valid in mem_ack_o cycle, held after
mem_ack_o  out  1  one-cycle completion pulse
stallreq_mem_o  out  1  mem_req_i & ~mem_ack_o (combinational)
bus_stb_o  out  1  bus strobe (registered)
bus_we_o  out  1  bus write enable (registered)
bus_sel_o  out  DATA_W/8  bus byte enables (registered)
bus_addr_o  out  ADDR_W  bus address (registered)
bus_wdata_o  out  DATA_W  bus write data (registered)
bus_rdata_i  in  DATA_W  slave read data, valid with bus_ack_i
bus_ack_i  in  1  slave completion, sampled only while bus_stb_o=1
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst=1): state=IDLE; all registered outputs 0, including stb, we, sel, addr, wdata, both rdata, both acks and err; timeout counter 0.
- States: IDLE, GNT_IF, GNT_MEM.
- IDLE, mem_req_i=1: go to GNT_MEM. Next edge loads bus_* from the MEM port and sets bus_stb_o=1.
- IDLE, only if_req_i=1: go to GNT_IF. Loads bus_addr_o=if_addr_i, bus_we_o=0, bus_sel_o=all ones, bus_wdata_o=0, bus_stb_o=1.
- Both requesting in IDLE: MEM wins (fixed priority; the older instruction goes first).
- GNT_x with bus_stb_o=1 and bus_ack_i=1: at the edge, stb=0 and all bus_* cleared to 0.
  - x_rdata_o <= bus_rdata_i, for writes too.
  - x_ack_o=1 for exactly one cycle; counter cleared; state=IDLE.
- Timing: request in cycle 0 → stb high in cycle 1 → slave ack in cycle 1 at earliest → requester ack in cycle 2.
- One mandatory IDLE cycle follows each transaction. Back-to-back grants are 2 cycles apart at best.
- Ack cycle interaction: in its ack cycle the requester may still show req=1. IDLE must not re-grant that port on that cycle's req; the ack_o pulse masks it.
- Timeout: counter increments each cycle stb=1 and bus_ack_i=0. When counter==TIMEOUT with no ack, the next edge:
  - drops stb and clears bus_*;
  - pulses x_ack_o and bus_err_o together;
  - sets x_rdata_o=0;
  - returns to IDLE.
- Ack arriving in the same cycle the counter hits TIMEOUT: normal completion, no error.
- Requester deasserting req mid-transaction: the transaction still completes; the ack pulse is still issued.
- Request inputs are ignored outside IDLE. Address and data are captured at grant; later changes have no effect.
- bus_ack_i while stb=0: ignored.
- rst asserted mid-transaction: immediate return to reset values, no ack issued.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x00000040; slave acks 1 cycle after stb with rdata 0x3C010001 → stb high for 1 cycle, bus_sel_o=0xF, we=0, if_ack_o pulses in cycle 2, if_rdata_o=0x3C010001, stallreq_if_o=1 in cycles 0-1 and 0 in cycle 2.
- Simultaneous requests: both req in the same cycle, MEM write to addr 0x100 with wdata 0xDEADBEEF and sel 0x3 → MEM is granted first with bus_we_o=1, sel=0x3; mem_ack_o pulses; after one IDLE cycle the IF grant begins; if_ack_o follows.
- Slave wait states: slave delays ack 5 cycles → stb held 6 cycles, bus_addr_o stable throughout, requester input changes have no effect, single ack pulse.
- Timeout: TIMEOUT=4, slave never acks → stb high 5 cycles, then mem_ack_o and bus_err_o pulse together, mem_rdata_o=0, state IDLE, next request served normally.
- Reset mid-transaction: assert rst while stb=1 → all outputs 0 immediately without waiting for a clock edge; no ack issued; after release, a fresh request completes normally.
- Ack at the limit: TIMEOUT=4, ack in the 5th stb cycle → normal completion, bus_err_o stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed-priority arbiter sharing one memory bus between fetch and load/store ports
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    output logic                stallreq_if_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                stallreq_mem_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                bus_err_o
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic       done;
    logic       expire;
    logic       grant_mem;
    logic       grant_if;

    // An ack pulse masks the still-raised request of the port it completes
    assign grant_mem      = mem_req_i & ~mem_ack_o;
    assign grant_if       = if_req_i & ~if_ack_o & ~grant_mem;
    assign done           = bus_stb_o & bus_ack_i;
    assign expire         = bus_stb_o & ~bus_ack_i & (cnt == 8'(TIMEOUT));
    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: grant from IDLE, return to IDLE on ack or timeout
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = grant_mem ? GNT_MEM : grant_if ? GNT_IF : IDLE;
        else if (done || expire)
            state_nx = IDLE;
    end

    // Bus drive, response capture, ack/err pulses and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            bus_err_o   <= 1'b0;
            cnt         <= '0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (grant_mem) begin
                    bus_stb_o   <= 1'b1;
                    bus_we_o    <= mem_we_i;
                    bus_sel_o   <= mem_sel_i;
                    bus_addr_o  <= mem_addr_i;
                    bus_wdata_o <= mem_wdata_i;
                end else if (grant_if) begin
                    bus_stb_o   <= 1'b1;
                    bus_we_o    <= 1'b0;
                    bus_sel_o   <= '1;
                    bus_addr_o  <= if_addr_i;
                    bus_wdata_o <= '0;
                end
            end else if (done || expire) begin
                bus_stb_o   <= 1'b0;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= '0;
                bus_addr_o  <= '0;
                bus_wdata_o <= '0;
                cnt         <= '0;
                bus_err_o   <= expire;
                if (state == GNT_IF) begin
                    if_ack_o   <= 1'b1;
                    if_rdata_o <= done ? bus_rdata_i : '0;
                end else begin
                    mem_ack_o   <= 1'b1;
                    mem_rdata_o <= done ? bus_rdata_i : '0;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of arbitration, wait states, timeout and reset
module tb_bus_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        if_req = 0, mem_req = 0, mem_we = 0, bus_ack = 0;
    logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
    logic [3:0]  mem_sel = 0;
    // main instance (TIMEOUT=255)
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, st_if, st_mem, bus_stb, bus_we, bus_err;
    logic [3:0]  bus_sel;
    // short-timeout instance (TIMEOUT=4)
    logic [31:0] t_if_rdata, t_mem_rdata, t_bus_addr, t_bus_wdata;
    logic        t_if_ack, t_mem_ack, t_st_if, t_st_mem, t_bus_stb, t_bus_we, t_bus_err;
    logic [3:0]  t_bus_sel;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_ack_o(if_ack), .stallreq_if_o(st_if), .mem_req_i(mem_req), .mem_we_i(mem_we),
        .mem_sel_i(mem_sel), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
        .mem_ack_o(mem_ack), .stallreq_mem_o(st_mem), .bus_stb_o(bus_stb), .bus_we_o(bus_we),
        .bus_sel_o(bus_sel), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack), .bus_err_o(bus_err)
    );

    bus_arbiter #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(t_if_rdata),
        .if_ack_o(t_if_ack), .stallreq_if_o(t_st_if), .mem_req_i(mem_req), .mem_we_i(mem_we),
        .mem_sel_i(mem_sel), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(t_mem_rdata),
        .mem_ack_o(t_mem_ack), .stallreq_mem_o(t_st_mem), .bus_stb_o(t_bus_stb), .bus_we_o(t_bus_we),
        .bus_sel_o(t_bus_sel), .bus_addr_o(t_bus_addr), .bus_wdata_o(t_bus_wdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack), .bus_err_o(t_bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        {if_req, mem_req, mem_we, bus_ack} = '0;
        {if_addr, mem_addr, mem_wdata, bus_rdata, mem_sel} = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata, if_ack, mem_ack, bus_err} !== '0) begin
            fails++;
            $display("FAIL reset_state: stb=%b addr=%h ack=%b/%b err=%b, all required 0", bus_stb, bus_addr, if_ack, mem_ack, bus_err);
        end
    endtask

    task automatic test_single_fetch;
        do_reset();
        if_req = 1; if_addr = 32'h40;
        #1;
        tests++;
        if (st_if !== 1'b1) begin fails++; $display("FAIL fetch_stall_c0: got %b want 1", st_if); end
        tick();
        tests++;
        if ({bus_stb, bus_we, bus_sel, bus_addr, st_if} !== {1'b1, 1'b0, 4'hF, 32'h40, 1'b1}) begin
            fails++;
            $display("FAIL fetch_bus_c1: stb=%b we=%b sel=%h addr=%h stall=%b want 1 0 f 00000040 1", bus_stb, bus_we, bus_sel, bus_addr, st_if);
        end
        bus_ack = 1; bus_rdata = 32'h3C010001;
        tick();
        bus_ack = 0;
        tests++;
        if ({if_ack, if_rdata, bus_stb, st_if, bus_addr} !== {1'b1, 32'h3C010001, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL fetch_ack_c2: ack=%b rdata=%h stb=%b stall=%b addr=%h want 1 3c010001 0 0 0", if_ack, if_rdata, bus_stb, st_if, bus_addr);
        end
        tick();
        if_req = 0;
        tests++;
        if ({if_ack, bus_stb, if_rdata} !== {1'b0, 1'b0, 32'h3C010001}) begin
            fails++;
            $display("FAIL fetch_no_regrant: ack=%b stb=%b rdata=%h want 0 0 3c010001", if_ack, bus_stb, if_rdata);
        end
    endtask

    task automatic test_priority;
        do_reset();
        if_req = 1; if_addr = 32'h80;
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; mem_sel = 4'h3;
        tick();
        tests++;
        if ({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL prio_mem_grant: stb=%b we=%b sel=%h addr=%h wdata=%h", bus_stb, bus_we, bus_sel, bus_addr, bus_wdata);
        end
        bus_ack = 1; bus_rdata = 32'h11111111;
        tick();
        bus_ack = 0;
        tests++;
        if ({mem_ack, mem_rdata, if_ack, bus_stb} !== {1'b1, 32'h11111111, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL prio_mem_ack: mack=%b mrdata=%h iack=%b stb=%b want 1 11111111 0 0", mem_ack, mem_rdata, if_ack, bus_stb);
        end
        mem_req = 0;
        tick();
        tests++;
        if ({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h80, 32'h0}) begin
            fails++;
            $display("FAIL prio_if_grant: stb=%b we=%b sel=%h addr=%h wdata=%h", bus_stb, bus_we, bus_sel, bus_addr, bus_wdata);
        end
        bus_ack = 1; bus_rdata = 32'h22222222;
        tick();
        bus_ack = 0; if_req = 0;
        tests++;
        if ({if_ack, if_rdata, mem_ack, mem_rdata} !== {1'b1, 32'h22222222, 1'b0, 32'h11111111}) begin
            fails++;
            $display("FAIL prio_if_ack: iack=%b irdata=%h mack=%b mrdata=%h", if_ack, if_rdata, mem_ack, mem_rdata);
        end
    endtask

    task automatic test_wait_states;
        int bad = 0;
        do_reset();
        mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
        tick();
        mem_addr = 32'h999; mem_we = 1; mem_sel = 4'h1;
        for (int i = 0; i < 5; i++) begin
            if ({bus_stb, bus_addr, bus_we, bus_sel, mem_ack, st_mem} !== {1'b1, 32'h200, 1'b0, 4'hF, 1'b0, 1'b1}) bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL wait_hold: %0d bad cycles, want 0", bad); end
        tests++;
        if ({bus_stb, bus_addr} !== {1'b1, 32'h200}) begin
            fails++;
            $display("FAIL wait_c6: stb=%b addr=%h want 1 00000200", bus_stb, bus_addr);
        end
        bus_ack = 1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 0;
        tests++;
        if ({mem_ack, mem_rdata, bus_stb} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            fails++;
            $display("FAIL wait_ack: ack=%b rdata=%h stb=%b want 1 cafef00d 0", mem_ack, mem_rdata, bus_stb);
        end
        mem_req = 0;
        bus_ack = 1;
        tick();
        tests++;
        if ({mem_ack, bus_stb} !== 2'b00) begin
            fails++;
            $display("FAIL wait_single_pulse: ack=%b stb=%b want 0 0", mem_ack, bus_stb);
        end
        bus_ack = 0;
    endtask

    task automatic test_timeout;
        int bad = 0;
        do_reset();
        mem_req = 1; mem_addr = 32'h300; mem_sel = 4'hF; bus_rdata = 32'hAAAAAAAA;
        tick();
        for (int i = 0; i < 5; i++) begin
            if ({t_bus_stb, t_bus_err, t_mem_ack} !== 3'b100) bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL timeout_stb5: %0d bad cycles, want 0", bad); end
        tests++;
        if ({t_mem_ack, t_bus_err, t_mem_rdata, t_bus_stb, t_bus_addr} !== {1'b1, 1'b1, 32'h0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL timeout_abort: ack=%b err=%b rdata=%h stb=%b addr=%h want 1 1 0 0 0", t_mem_ack, t_bus_err, t_mem_rdata, t_bus_stb, t_bus_addr);
        end
        mem_req = 0;
        tick();
        tests++;
        if ({t_mem_ack, t_bus_err, t_bus_stb} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_idle: ack=%b err=%b stb=%b want 0 0 0", t_mem_ack, t_bus_err, t_bus_stb);
        end
        if_req = 1; if_addr = 32'h44;
        tick();
        bus_ack = 1; bus_rdata = 32'h55;
        tick();
        bus_ack = 0; if_req = 0;
        tests++;
        if ({t_if_ack, t_if_rdata, t_bus_err} !== {1'b1, 32'h55, 1'b0}) begin
            fails++;
            $display("FAIL timeout_recover: ack=%b rdata=%h err=%b want 1 00000055 0", t_if_ack, t_if_rdata, t_bus_err);
        end
    endtask

    task automatic test_ack_at_limit;
        do_reset();
        mem_req = 1; mem_addr = 32'h400; mem_sel = 4'hF;
        tick();
        repeat (4) tick();
        tests++;
        if ({t_bus_stb, t_mem_ack} !== 2'b10) begin
            fails++;
            $display("FAIL limit_c5: stb=%b ack=%b want 1 0", t_bus_stb, t_mem_ack);
        end
        bus_ack = 1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 0; mem_req = 0;
        tests++;
        if ({t_mem_ack, t_bus_err, t_mem_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
            fails++;
            $display("FAIL limit_ack: ack=%b err=%b rdata=%h want 1 0 12345678", t_mem_ack, t_bus_err, t_mem_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        do_reset();
        mem_req = 1; mem_we = 1; mem_addr = 32'h500; mem_wdata = 32'h77; mem_sel = 4'hF;
        tick();
        #2;
        rst = 1;
        #1;
        tests++;
        if ({bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, mem_ack} !== '0) begin
            fails++;
            $display("FAIL rst_async: stb=%b we=%b addr=%h wdata=%h ack=%b want all 0", bus_stb, bus_we, bus_addr, bus_wdata, mem_ack);
        end
        mem_req = 0;
        bus_ack = 1;
        tick();
        rst = 0;
        bus_ack = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_ack) acks++;
            tick();
        end
        tests++;
        if (acks !== 0) begin fails++; $display("FAIL rst_no_ack: %0d acks, want 0", acks); end
        mem_req = 1; mem_we = 0; mem_addr = 32'h600;
        tick();
        bus_ack = 1; bus_rdata = 32'h66;
        tick();
        bus_ack = 0; mem_req = 0;
        tests++;
        if ({mem_ack, mem_rdata} !== {1'b1, 32'h66}) begin
            fails++;
            $display("FAIL rst_fresh: ack=%b rdata=%h want 1 00000066", mem_ack, mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_wait_states();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
